// File: rtl/bsg_link_reset_sequencer_pkg.sv
// Shared types for the link reset sequencer: state encoding and width helpers.
package bsg_link_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_IORST   = 3'd1,
    S_IOREL   = 3'd2,
    S_LINKEN  = 3'd3,
    S_CHIPREL = 3'd4,
    S_NODEEN  = 3'd5
  } state_e;

  localparam int unsigned state_width_gp = 3;

  // Keeps counters at least one bit wide when the range collapses to a single value.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_link_reset_sequencer_if.sv
// Per-link bundle between the reset sequencer and the link stacks it controls.
interface bsg_link_reset_sequencer_if #(
  parameter int unsigned num_links_p = 1
);

  logic [num_links_p-1:0] link_mask_i;
  logic [num_links_p-1:0] link_error_i;
  logic [num_links_p-1:0] link_io_reset_o;
  logic [num_links_p-1:0] chip_reset_o;
  logic [num_links_p-1:0] link_enable_o;
  logic [num_links_p-1:0] node_en_o;

  modport slave (
    input  link_mask_i,
    input  link_error_i,
    output link_io_reset_o,
    output chip_reset_o,
    output link_enable_o,
    output node_en_o
  );

  modport master (
    output link_mask_i,
    output link_error_i,
    input  link_io_reset_o,
    input  chip_reset_o,
    input  link_enable_o,
    input  node_en_o
  );

endinterface

// File: rtl/bsg_link_reset_sequencer_phase_timer.sv
// Dwell counter: counts while enabled, wraps to zero after reaching phase_cycles_p.
module bsg_link_reset_sequencer_phase_timer #(
  parameter int unsigned phase_cycles_p = 5000,
  parameter int unsigned cnt_width_p    = 13
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [cnt_width_p-1:0] count_q, count_d;

  assign tc_o = (count_q == cnt_width_p'(phase_cycles_p));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bsg_link_reset_sequencer.sv
// Five-step link bring-up sequencer with per-link masking and synchronous restart.
// Optional auto-retry on link errors: define BSG_LINK_RESET_SEQUENCER_AUTO_RETRY_EN.
module bsg_link_reset_sequencer
  import bsg_link_reset_sequencer_pkg::*;
#(
  parameter  int unsigned num_links_p    = 1,
  parameter  int unsigned phase_cycles_p = 5000,
  parameter  int unsigned max_retries_p  = 3,
  localparam int unsigned cnt_width_lp   = safe_clog2(phase_cycles_p + 1),
  localparam int unsigned retry_width_lp = safe_clog2(max_retries_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             restart_i,
  bsg_link_reset_sequencer_if.slave        link_if,
  output logic                             done_o,
  output logic [state_width_gp-1:0]        state_o,
  output logic [retry_width_lp-1:0]        retry_count_o
);

  state_e state_q, state_d;

  logic io_reset_q,    io_reset_d;
  logic chip_reset_q,  chip_reset_d;
  logic link_enable_q, link_enable_d;
  logic node_en_q,     node_en_d;
  logic done_q,        done_d;

  logic [num_links_p-1:0] mask_q;

  logic timer_en;
  logic timer_tc;
  logic advance;
  logic auto_restart;
  logic restart_all;

  assign timer_en    = (state_q != S_NODEEN);
  assign advance     = timer_en & timer_tc;
  assign restart_all = restart_i | auto_restart;

  bsg_link_reset_sequencer_phase_timer #(
    .phase_cycles_p (phase_cycles_p),
    .cnt_width_p    (cnt_width_lp)
  ) phase_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (restart_all),
    .en_i      (timer_en),
    .tc_o      (timer_tc)
  );

`ifdef BSG_LINK_RESET_SEQUENCER_AUTO_RETRY_EN
  logic                      err_hit_q, err_hit_d;
  logic [retry_width_lp-1:0] retry_q,   retry_d;
  logic                      retry_room;

  assign retry_room = (retry_q < retry_width_lp'(max_retries_p));

  // An error seen in the terminal state is latched, and the restart it causes lands one edge later;
  // the ~err_hit_q term stops a held error from queueing a second restart.
  always_comb begin
    err_hit_d = (state_q == S_NODEEN) && |(link_if.link_error_i & link_if.link_mask_i)
                && retry_room && !err_hit_q;
    retry_d   = retry_q;
    if (err_hit_q && retry_room) begin
      retry_d = retry_q + retry_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_hit_q <= 1'b0;
      retry_q   <= '0;
    end else begin
      err_hit_q <= err_hit_d;
      retry_q   <= retry_d;
    end
  end

  assign auto_restart  = err_hit_q;
  assign retry_count_o = retry_q;
`else
  logic unused_link_error;

  assign unused_link_error = ^link_if.link_error_i;
  assign auto_restart      = 1'b0;
  assign retry_count_o     = '0;
`endif

  always_comb begin
    state_d       = state_q;
    io_reset_d    = io_reset_q;
    chip_reset_d  = chip_reset_q;
    link_enable_d = link_enable_q;
    node_en_d     = node_en_q;
    done_d        = done_q;
    if (restart_all) begin
      state_d       = S_WAIT;
      io_reset_d    = 1'b0;
      chip_reset_d  = 1'b1;
      link_enable_d = 1'b0;
      node_en_d     = 1'b0;
      done_d        = 1'b0;
    end else if (advance) begin
      case (state_q)
        S_WAIT: begin
          state_d    = S_IORST;
          io_reset_d = 1'b1;
        end
        S_IORST: begin
          state_d    = S_IOREL;
          io_reset_d = 1'b0;
        end
        S_IOREL: begin
          state_d       = S_LINKEN;
          link_enable_d = 1'b1;
        end
        S_LINKEN: begin
          state_d      = S_CHIPREL;
          chip_reset_d = 1'b0;
        end
        S_CHIPREL: begin
          state_d   = S_NODEEN;
          node_en_d = 1'b1;
          done_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= S_WAIT;
      io_reset_q    <= 1'b0;
      chip_reset_q  <= 1'b1;
      link_enable_q <= 1'b0;
      node_en_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      io_reset_q    <= io_reset_d;
      chip_reset_q  <= chip_reset_d;
      link_enable_q <= link_enable_d;
      node_en_q     <= node_en_d;
      done_q        <= done_d;
    end
  end

  // Mask resets to zero; that still leaves every link in chip reset with its other outputs low.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mask_q <= '0;
    end else begin
      mask_q <= link_if.link_mask_i;
    end
  end

  assign link_if.link_io_reset_o = {num_links_p{io_reset_q}}    & mask_q;
  assign link_if.chip_reset_o    = {num_links_p{chip_reset_q}}  | ~mask_q;
  assign link_if.link_enable_o   = {num_links_p{link_enable_q}} & mask_q;
  assign link_if.node_en_o       = {num_links_p{node_en_q}}     & mask_q;

  assign done_o  = done_q;
  assign state_o = state_q;

endmodule
